// File: rtl/usb_tx_packet_sequencer.sv
// USB full-speed transmit packet sequencer.
// Builds DATA0/DATA1/auto-toggle data packets and ACK/NAK/STALL handshakes
// as a byte stream: SYNC, PID, FIFO payload, CRC16. The stream then goes
// through a valid/ready handshake to the serializer, and EOP is requested
// from the line driver.
//
// Ports:
//   clk, n_rst                    clock, async active-low reset
//   tx_start/tx_type/tx_size      packet request (sampled only in IDLE)
//   fifo_rd_data/fifo_empty       FWFT TX FIFO head; fifo_rd_en pops it
//   byte_out/byte_valid/byte_ready  byte stream to serializer
//   eop_req/eop_done              EOP request / completion pulse
//   host_ack/toggle_clear         auto data-toggle control
//   busy/tx_done/tx_error         status; data_toggle = current auto toggle
module usb_tx_packet_sequencer #(
    parameter int          MAX_PAYLOAD = 64,
    parameter int          SIZE_W      = 7,
    parameter logic [7:0]  SYNC_BYTE   = 8'h80
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              tx_start,
    input  logic [2:0]        tx_type,
    input  logic [SIZE_W-1:0] tx_size,
    input  logic [7:0]        fifo_rd_data,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              eop_req,
    input  logic              eop_done,
    input  logic              host_ack,
    input  logic              toggle_clear,
    output logic              busy,
    output logic              tx_done,
    output logic              tx_error,
    output logic              data_toggle
);

    localparam logic [2:0] T_DATA0 = 3'd1;
    localparam logic [2:0] T_DATA1 = 3'd2;
    localparam logic [2:0] T_AUTO  = 3'd3;
    localparam logic [2:0] T_ACK   = 3'd4;
    localparam logic [2:0] T_NAK   = 3'd5;
    localparam logic [2:0] T_STALL = 3'd6;

    localparam logic [SIZE_W-1:0] MAX_SZ = SIZE_W'(MAX_PAYLOAD);
    localparam logic [SIZE_W-1:0] ONE    = SIZE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        pid_q, pid_d;
    logic              hs_q, hs_d;          // handshake packet: no payload/CRC
    logic              auto_q, auto_d;      // packet uses the auto toggle
    logic [SIZE_W-1:0] size_q, size_d;
    logic [SIZE_W-1:0] cnt_q, cnt_d;
    logic [15:0]       crc_q, crc_d;
    logic              under_q, under_d;    // underrun: suppress tx_done
    logic              pend_q, pend_d;      // last completed packet was DATA_AUTO
    logic              toggle_q, toggle_d;
    logic              tx_done_q, tx_done_d;
    logic              tx_error_q, tx_error_d;
    logic              accept;
    logic              xfer;

    // Reflected CRC16 (poly A001), one byte per cycle, LSB first.
    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // Byte stream decode
    always_comb begin
        byte_out   = 8'h00;
        byte_valid = 1'b0;
        case (state_q)
            S_SYNC: begin
                byte_valid = 1'b1;
                byte_out   = SYNC_BYTE;
            end
            S_PID: begin
                byte_valid = 1'b1;
                byte_out   = {~pid_q, pid_q};
            end
            S_DATA: begin
                byte_valid = !fifo_empty;
                byte_out   = fifo_rd_data;
            end
            S_CRC_LO: begin
                byte_valid = 1'b1;
                byte_out   = ~crc_q[7:0];
            end
            S_CRC_HI: begin
                byte_valid = 1'b1;
                byte_out   = ~crc_q[15:8];
            end
            default: ;
        endcase
    end

    assign xfer        = byte_valid && byte_ready;
    assign fifo_rd_en  = (state_q == S_DATA) && xfer;
    assign eop_req     = (state_q == S_EOP);
    assign busy        = (state_q != S_IDLE);
    assign tx_done     = tx_done_q;
    assign tx_error    = tx_error_q;
    assign data_toggle = toggle_q;

    // Next state
    always_comb begin
        state_d    = state_q;
        pid_d      = pid_q;
        hs_d       = hs_q;
        auto_d     = auto_q;
        size_d     = size_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        under_d    = under_q;
        pend_d     = pend_q;
        toggle_d   = toggle_q;
        tx_done_d  = 1'b0;
        tx_error_d = 1'b0;
        accept     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    case (tx_type)
                        T_DATA0, T_DATA1, T_AUTO: begin
                            if (tx_size > MAX_SZ) tx_error_d = 1'b1;
                            else                  accept     = 1'b1;
                        end
                        T_ACK, T_NAK, T_STALL: accept = 1'b1;
                        default: ;
                    endcase
                end
                if (accept) begin
                    state_d = S_SYNC;
                    hs_d    = (tx_type >= T_ACK);
                    auto_d  = (tx_type == T_AUTO);
                    size_d  = (tx_type >= T_ACK) ? '0 : tx_size;
                    cnt_d   = '0;
                    crc_d   = 16'hFFFF;
                    under_d = 1'b0;
                    pend_d  = 1'b0;
                    case (tx_type)
                        T_DATA0: pid_d = 4'h3;
                        T_DATA1: pid_d = 4'hB;
                        T_AUTO:  pid_d = toggle_q ? 4'hB : 4'h3;
                        T_ACK:   pid_d = 4'h2;
                        T_NAK:   pid_d = 4'hA;
                        default: pid_d = 4'hE;
                    endcase
                end
            end
            S_SYNC: if (xfer) state_d = S_PID;
            S_PID: begin
                if (xfer) begin
                    if (hs_q)               state_d = S_EOP;
                    else if (size_q != '0)  state_d = S_DATA;
                    else                    state_d = S_CRC_LO;
                end
            end
            S_DATA: begin
                if (fifo_empty) begin
                    // Truncated packet: the host drops it on the bad CRC.
                    state_d    = S_EOP;
                    under_d    = 1'b1;
                    tx_error_d = 1'b1;
                end else if (xfer) begin
                    crc_d = crc16_upd(crc_q, fifo_rd_data);
                    cnt_d = cnt_q + ONE;
                    if (cnt_q + ONE == size_q) state_d = S_CRC_LO;
                end
            end
            S_CRC_LO: if (xfer) state_d = S_CRC_HI;
            S_CRC_HI: if (xfer) state_d = S_EOP;
            S_EOP: begin
                if (eop_done) begin
                    state_d = S_IDLE;
                    if (!under_q) begin
                        tx_done_d = 1'b1;
                        pend_d    = auto_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An ack only counts against the last finished DATA_AUTO packet,
        // and not once a newer packet is being accepted.
        if (toggle_clear)
            toggle_d = 1'b0;
        else if (host_ack && pend_q && state_q == S_IDLE && !accept)
            toggle_d = ~toggle_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            pid_q      <= '0;
            hs_q       <= 1'b0;
            auto_q     <= 1'b0;
            size_q     <= '0;
            cnt_q      <= '0;
            crc_q      <= '0;
            under_q    <= 1'b0;
            pend_q     <= 1'b0;
            toggle_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pid_q      <= pid_d;
            hs_q       <= hs_d;
            auto_q     <= auto_d;
            size_q     <= size_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            under_q    <= under_d;
            pend_q     <= pend_d;
            toggle_q   <= toggle_d;
            tx_done_q  <= tx_done_d;
            tx_error_q <= tx_error_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_packet_sequencer.sv
// Directed bench for usb_tx_packet_sequencer: byte streams, CRC, FIFO pops,
// back-pressure stability, auto toggle, reject/underrun and reset.
module tb_usb_tx_packet_sequencer;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start, byte_ready, eop_done, host_ack, toggle_clear;
    logic [2:0] tx_type;
    logic [6:0] tx_size;
    logic [7:0] fifo_rd_data, byte_out;
    logic       fifo_empty, fifo_rd_en, byte_valid, eop_req;
    logic       busy, tx_done, tx_error, data_toggle;

    usb_tx_packet_sequencer dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_type(tx_type),
        .tx_size(tx_size), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .eop_req(eop_req), .eop_done(eop_done),
        .host_ack(host_ack), .toggle_clear(toggle_clear), .busy(busy),
        .tx_done(tx_done), .tx_error(tx_error), .data_toggle(data_toggle)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [7:0] fmem[$];
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    int rd_cnt, done_cnt, err_cnt, cyc = 0, done_cyc, eop_cyc;
    bit vld_seen, eop_seen, pop_pend = 0, bp = 0, stalled = 0;
    logic [7:0] stall_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r = c;
        for (int i = 0; i < 8; i++)
            r = ((r[0] ^ d[i]) != 1'b0) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    task automatic fifo_upd();
        fifo_empty   = (fmem.size() == 0);
        fifo_rd_data = fifo_empty ? 8'h00 : fmem[0];
    endtask

    task automatic step();
        @(posedge clk); #1;
        if (pop_pend) begin
            if (fmem.size() > 0) void'(fmem.pop_front());
            pop_pend = 0;
        end
        fifo_upd();
    endtask

    // Monitor: sampled mid-cycle, inputs change just after the rising edge.
    always @(negedge clk) begin
        cyc++;
        if (n_rst) begin
            if (bp && stalled) begin
                chk("bp_valid_held", 32'(byte_valid), 32'd1);
                chk("bp_byte_held", 32'(byte_out), 32'(stall_byte));
            end
            if (byte_valid && byte_ready) cap.push_back(byte_out);
            if (byte_valid) vld_seen = 1;
            if (fifo_rd_en) begin rd_cnt++; pop_pend = 1; end
            if (tx_done) begin done_cnt++; done_cyc = cyc; end
            if (tx_error) err_cnt++;
            if (eop_req) eop_seen = 1;
            if (eop_done) eop_cyc = cyc;
            stalled    = byte_valid && !byte_ready;
            stall_byte = byte_out;
        end else begin
            stalled = 0;
        end
    end

    task automatic send(input logic [2:0] t, input logic [6:0] sz);
        bit fin = 0;
        cap.delete(); rd_cnt = 0; done_cnt = 0; err_cnt = 0;
        vld_seen = 0; eop_seen = 0; done_cyc = 0; eop_cyc = 0;
        tx_type = t; tx_size = sz; tx_start = 1'b1;
        step();
        tx_start = 1'b0; tx_type = 3'd0; tx_size = 7'd0;
        for (int i = 0; i < 300 && !fin; i++) begin
            eop_done = busy && eop_req;
            if (!busy) fin = 1;
            else begin
                if (bp) byte_ready = 1'($urandom_range(0, 1));
                step();
            end
        end
        eop_done = 1'b0; byte_ready = 1'b1;
        chk("send_finished", 32'(fin), 32'd1);
        step(); step();
    endtask

    task automatic chk_bytes(input string tag);
        chk({tag, "_len"}, 32'(cap.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(cap[i]), 32'(exp_q[i]));
    endtask

    task automatic ack_pulse(input logic clr);
        host_ack = 1'b1; toggle_clear = clr;
        step();
        host_ack = 1'b0; toggle_clear = 1'b0;
    endtask

    initial begin
        logic [15:0] c;
        n_rst = 1'b0; tx_start = 0; tx_type = 0; tx_size = 0; byte_ready = 1;
        eop_done = 0; host_ack = 0; toggle_clear = 0;
        fifo_upd();
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(byte_valid), 0);
        chk("rst_byte", 32'(byte_out), 0);
        chk("rst_eop", 32'(eop_req), 0);
        chk("rst_toggle", 32'(data_toggle), 0);
        step(); n_rst = 1'b1; step();

        // ACK handshake
        send(3'd4, 7'd0);
        exp_q = '{8'h80, 8'hD2}; chk_bytes("ack");
        chk("ack_done", 32'(done_cnt), 1);
        chk("ack_done_lat", 32'(done_cyc - eop_cyc), 1);
        chk("ack_eop_seen", 32'(eop_seen), 1);
        chk("ack_rd", 32'(rd_cnt), 0);

        // Zero-length DATA1
        send(3'd2, 7'd0);
        exp_q = '{8'h80, 8'h4B, 8'h00, 8'h00}; chk_bytes("d1z");
        chk("d1z_done", 32'(done_cnt), 1);

        // DATA0, one byte 00
        fmem = '{8'h00}; fifo_upd();
        send(3'd1, 7'd1);
        exp_q = '{8'h80, 8'hC3, 8'h00, 8'h40, 8'hBF}; chk_bytes("d0b1");
        chk("d0b1_rd", 32'(rd_cnt), 1);
        chk("d0b1_done", 32'(done_cnt), 1);

        // Back-pressure, DATA0 size 3
        fmem = '{8'hA5, 8'h3C, 8'hF0}; fifo_upd();
        c = crc_step(crc_step(crc_step(16'hFFFF, 8'hA5), 8'h3C), 8'hF0);
        bp = 1;
        send(3'd1, 7'd3);
        bp = 0;
        exp_q = '{8'h80, 8'hC3, 8'hA5, 8'h3C, 8'hF0, ~c[7:0], ~c[15:8]}; chk_bytes("bp");
        chk("bp_rd", 32'(rd_cnt), 3);
        chk("bp_fifo_drained", 32'(fifo_empty), 1);

        // Oversize reject
        send(3'd1, 7'd65);
        chk("rej_err", 32'(err_cnt), 1);
        chk("rej_no_valid", 32'(vld_seen), 0);
        chk("rej_no_done", 32'(done_cnt), 0);

        // Underrun: size 4, only 2 bytes in FIFO
        fmem = '{8'h11, 8'h22}; fifo_upd();
        send(3'd1, 7'd4);
        exp_q = '{8'h80, 8'hC3, 8'h11, 8'h22}; chk_bytes("und");
        chk("und_err", 32'(err_cnt), 1);
        chk("und_no_done", 32'(done_cnt), 0);
        chk("und_eop", 32'(eop_seen), 1);

        // Auto toggle
        send(3'd3, 7'd0);
        chk("auto1_pid", 32'(cap[1]), 32'hC3);
        ack_pulse(1'b0);
        chk("auto1_ack_tog", 32'(data_toggle), 1);
        send(3'd3, 7'd0);
        chk("auto2_pid", 32'(cap[1]), 32'h4B);
        ack_pulse(1'b1);
        chk("auto2_clr_tog", 32'(data_toggle), 0);
        send(3'd3, 7'd0);
        chk("auto3_pid", 32'(cap[1]), 32'hC3);
        ack_pulse(1'b1);
        chk("auto3_clr_prio", 32'(data_toggle), 0);
        send(3'd1, 7'd0);
        chk("expl_pid", 32'(cap[1]), 32'hC3);
        ack_pulse(1'b0);
        chk("expl_no_flip", 32'(data_toggle), 0);
        send(3'd3, 7'd0);
        chk("auto4_pid", 32'(cap[1]), 32'hC3);
        ack_pulse(1'b0);
        chk("auto4_ack_tog", 32'(data_toggle), 1);

        // Reset mid-DATA
        fmem = '{8'h5A, 8'h6B, 8'h7C, 8'h8D}; fifo_upd();
        tx_type = 3'd1; tx_size = 7'd4; tx_start = 1'b1; byte_ready = 1'b1;
        step();
        tx_start = 1'b0;
        step(); step();
        byte_ready = 1'b0;
        chk("mid_valid", 32'(byte_valid), 1);
        chk("mid_byte", 32'(byte_out), 32'h5A);
        #2 n_rst = 1'b0; #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_valid", 32'(byte_valid), 0);
        chk("mr_byte", 32'(byte_out), 0);
        chk("mr_rd", 32'(fifo_rd_en), 0);
        chk("mr_eop", 32'(eop_req), 0);
        chk("mr_done_err", 32'({tx_done, tx_error}), 0);
        chk("mr_toggle", 32'(data_toggle), 0);
        step(); n_rst = 1'b1; byte_ready = 1'b1; tx_type = 3'd0; tx_size = 7'd0;
        fmem.delete(); fifo_upd();
        step();
        chk("post_rst_idle", 32'(busy), 0);
        send(3'd6, 7'd0);
        exp_q = '{8'h80, 8'h1E}; chk_bytes("stall");
        chk("stall_done", 32'(done_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
